// File: rtl/handshake_arbiter.sv
// -----------------------------------------------------------------------------
// handshake_arbiter
//
// Purpose:
//   Shares one valid/ready output channel among N valid/ready requesters with
//   round-robin fairness. A grant can be held for a burst. The burst ends on
//   the requester's i_last or after MAX_BURST beats, whichever comes first.
//   The output has one registered stage. It advances when ~o_valid | i_ready,
//   so the arbiter sustains one beat per cycle.
//
// Parameters:
//   N         number of requesters (>= 2)
//   WIDTH     data width per beat
//   MAX_BURST maximum beats per grant (>= 1); 1 gives per-beat round robin
//
// Ports:
//   clock    in   rising-edge clock
//   reset_n  in   asynchronous reset, active-low
//   i_value  in   requester data, slice k = [k*WIDTH +: WIDTH]
//   i_valid  in   per-requester valid
//   i_last   in   per-requester end-of-burst marker, sampled with its beat
//   o_ready  out  per-requester ready (combinational)
//   o_value  out  arbitrated data (registered)
//   o_last   out  last flag of the forwarded beat (forced on MAX_BURST release)
//   o_valid  out  output valid (registered)
//   o_id     out  source index of the forwarded beat (only with
//                 HANDSHAKE_ARBITER_ID_EN defined)
//   i_ready  in   sink ready
//
// Configuration macro:
//   HANDSHAKE_ARBITER_ID_EN - adds the o_id port and its register.
// -----------------------------------------------------------------------------
module handshake_arbiter #(
    parameter int N         = 4,
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [N*WIDTH-1:0] i_value,
    input  logic [N-1:0]       i_valid,
    input  logic [N-1:0]       i_last,
    output logic [N-1:0]       o_ready,
    output logic [WIDTH-1:0]   o_value,
    output logic               o_last,
    output logic               o_valid,
`ifdef HANDSHAKE_ARBITER_ID_EN
    output logic [$clog2(N)-1:0] o_id,
`endif
    input  logic               i_ready
);

    localparam int PW = $clog2(N);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [PW-1:0]    prio_q, prio_d;
    logic [PW-1:0]    grant_q, grant_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic             last_q, last_d;
    logic             valid_q, valid_d;

    logic             m_ready;
    logic             locked;
    logic [PW-1:0]    winner;
    logic             any_valid;
    logic [PW-1:0]    sel;
    logic             offer;
    logic             xfer;
    logic             release_beat;
    logic [WIDTH-1:0] value_arr [N];

    // Per-requester data slices as an array so the selected beat is a plain mux.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_slice
            assign value_arr[gi] = i_value[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Round-robin scan starting at prio_q. The loop walks the scan order
    // backwards, so the requester that comes first in scan order is assigned
    // last and wins.
    always_comb begin
        int idx;
        winner    = '0;
        any_valid = 1'b0;
        idx       = 0;
        for (int off = N - 1; off >= 0; off--) begin
            idx = int'(prio_q) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (i_valid[idx]) begin
                winner    = PW'(idx);
                any_valid = 1'b1;
            end
        end
    end

    assign m_ready = ~valid_q | i_ready;
    assign locked  = (state_q == ST_LOCKED);

    // While locked, the granted requester keeps the channel even when its
    // valid is low. The other requesters stay blocked.
    assign sel          = locked ? grant_q : winner;
    assign offer        = m_ready & (locked | any_valid);
    assign xfer         = offer & i_valid[sel];
    assign release_beat = i_last[sel] | (cnt_q == CNT_LAST);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ready
            assign o_ready[gi] = offer & (sel == PW'(gi));
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        value_d = value_q;
        last_d  = last_q;
        valid_d = valid_q;
        if (xfer) begin
            value_d = value_arr[sel];
            valid_d = 1'b1;
            last_d  = release_beat;
            if (release_beat) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                prio_d  = (sel == PW'(N - 1)) ? '0 : sel + 1'b1;
            end else begin
                state_d = ST_LOCKED;
                grant_d = sel;
                cnt_d   = cnt_q + 1'b1;
            end
        end else if (m_ready) begin
            // The sink took the current beat (or none was held) and nothing new
            // arrived, so a bubble is emitted.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            prio_q  <= '0;
            grant_q <= '0;
            cnt_q   <= '0;
            value_q <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    assign o_value = value_q;
    assign o_last  = last_q;
    assign o_valid = valid_q;

`ifdef HANDSHAKE_ARBITER_ID_EN
    logic [PW-1:0] id_q;

    // The source index is captured together with the beat it describes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            id_q <= '0;
        end else if (xfer) begin
            id_q <= sel;
        end
    end

    assign o_id = id_q;
`endif

endmodule

// File: tb/tb_handshake_arbiter.sv
module tb_handshake_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;

    logic             clock = 1'b0;
    logic             reset_n;
    logic [N*W-1:0]   i_value;
    logic [N-1:0]     i_valid;
    logic [N-1:0]     i_last;
    logic [N-1:0]     o_ready;
    logic [W-1:0]     o_value;
    logic             o_last;
    logic             o_valid;
    logic             i_ready;
`ifdef HANDSHAKE_ARBITER_ID_EN
    logic [1:0]       o_id;
`endif

    always #5 clock = ~clock;

    handshake_arbiter #(.N(N), .WIDTH(W), .MAX_BURST(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .i_value (i_value),
        .i_valid (i_valid),
        .i_last  (i_last),
        .o_ready (o_ready),
        .o_value (o_value),
        .o_last  (o_last),
        .o_valid (o_valid),
`ifdef HANDSHAKE_ARBITER_ID_EN
        .o_id    (o_id),
`endif
        .i_ready (i_ready)
    );

    int total = 0;
    int bad   = 0;
    int beat_no = 0;

    // Per-source beat store: {last, value}
    logic [8:0]  src_mem [N][16];
    int          src_rd  [N];
    int          src_wr  [N];
    logic        src_en  [N];

    // Scoreboard: {id, last, value}
    logic [10:0] exp_q [$];

    logic [N-1:0] s_ready;
    logic         s_valid;
    logic [W-1:0] s_value;
    logic [N-1:0] acc;

    function automatic logic [7:0] bv(int k, int s);
        return 8'(k * 64 + s);
    endfunction

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            if (src_en[k] && src_rd[k] < src_wr[k]) begin
                i_valid[k]       = 1'b1;
                i_value[k*W +: W] = src_mem[k][src_rd[k]][7:0];
                i_last[k]        = src_mem[k][src_rd[k]][8];
            end else begin
                i_valid[k]       = 1'b0;
                i_value[k*W +: W] = 8'($urandom);
                i_last[k]        = 1'($urandom);
            end
        end
    endtask

    // lastmode: 0 = never, 1 = every beat, 2 = final beat only
    task automatic push_src(int k, int n, int lastmode);
        for (int i = 0; i < n; i++) begin
            logic lb;
            lb = (lastmode == 1) || (lastmode == 2 && i == n - 1);
            src_mem[k][src_wr[k]] = {lb, bv(k, src_wr[k])};
            src_wr[k]++;
        end
    endtask

    task automatic push_exp(logic [7:0] v, logic l, int id);
        exp_q.push_back({2'(id), l, v});
    endtask

    // One clock: sample at the falling edge, score accepted output beats,
    // then retire accepted source beats and re-drive after the rising edge.
    task automatic tick();
        logic [10:0] e;
        logic [1:0]  got_id;
        @(negedge clock);
        s_ready = o_ready;
        s_valid = o_valid;
        s_value = o_value;
        acc     = i_valid & o_ready;
        if (reset_n && o_valid && i_ready) begin
            total++;
            beat_no++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_extra: got value=%h last=%b, required no beat", o_value, o_last);
            end else begin
                e = exp_q.pop_front();
                got_id = e[10:9];
`ifdef HANDSHAKE_ARBITER_ID_EN
                got_id = o_id;
`endif
                if ({got_id, o_last, o_value} !== e) begin
                    bad++;
                    $display("FAIL sb_beat: got id=%0d last=%b value=%h, required id=%0d last=%b value=%h",
                             got_id, o_last, o_value, e[10:9], e[8], e[7:0]);
                end else begin
                    $display("beat %0d: id=%0d last=%b value=%h", beat_no, e[10:9], o_last, o_value);
                end
            end
        end
        @(posedge clock);
        #1;
        for (int k = 0; k < N; k++) begin
            if (acc[k]) src_rd[k]++;
        end
        drive();
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 300) begin
            tick();
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout: got %0d beats outstanding, required 0", exp_q.size());
        end
        repeat (3) tick();
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        i_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            src_rd[k] = 0;
            src_wr[k] = 0;
            src_en[k] = 1'b1;
        end
        exp_q.delete();
        drive();
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        i_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            src_rd[k] = 0;
            src_wr[k] = 0;
            src_en[k] = 1'b1;
        end
        drive();
        @(posedge clock);
        #1;
        total += 4;
        if (o_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b, required 0", o_valid); end
        if (o_value !== 8'h00) begin bad++; $display("FAIL rst_value: got %h, required 00", o_value); end
        if (o_last !== 1'b0) begin bad++; $display("FAIL rst_last: got %b, required 0", o_last); end
        if (o_ready !== 4'b0000) begin bad++; $display("FAIL rst_ready: got %b, required 0000", o_ready); end
`ifdef HANDSHAKE_ARBITER_ID_EN
        total++;
        if (o_id !== 2'd0) begin bad++; $display("FAIL rst_id: got %0d, required 0", o_id); end
`endif
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        apply_reset();
        push_src(2, 8, 2);
        for (int i = 0; i < 8; i++) push_exp(bv(2, i), (i == 3 || i == 7), 2);
        drive();
        tick();
        total += 2;
        if (s_ready !== 4'b0100) begin bad++; $display("FAIL single_ready0: got %b, required 0100", s_ready); end
        if (s_valid !== 1'b0) begin bad++; $display("FAIL single_lat0: got valid %b, required 0", s_valid); end
        tick();
        total++;
        if (s_valid !== 1'b1 || s_value !== bv(2, 0)) begin
            bad++;
            $display("FAIL single_lat1: got valid=%b value=%h, required valid=1 value=%h", s_valid, s_value, bv(2, 0));
        end
        for (int i = 2; i < 8; i++) begin
            tick();
            total++;
            if (s_ready[2] !== 1'b1) begin bad++; $display("FAIL single_ready: got %b at beat %0d, required 1", s_ready[2], i); end
        end
        drain();
    endtask

    task automatic test_rr_last();
        apply_reset();
        for (int k = 0; k < N; k++) push_src(k, 3, 1);
        for (int r = 0; r < 3; r++)
            for (int k = 0; k < N; k++) push_exp(bv(k, r), 1'b1, k);
        drive();
        drain();
    endtask

    task automatic test_rr_burst();
        apply_reset();
        for (int k = 0; k < N; k++) push_src(k, 4, 0);
        for (int k = 0; k < N; k++)
            for (int i = 0; i < 4; i++) push_exp(bv(k, i), (i == 3), k);
        drive();
        drain();
    endtask

    task automatic test_lock_hold();
        int n;
        apply_reset();
        push_src(1, 4, 0);
        push_src(3, 2, 2);
        for (int i = 0; i < 4; i++) push_exp(bv(1, i), (i == 3), 1);
        for (int i = 0; i < 2; i++) push_exp(bv(3, i), (i == 1), 3);
        drive();
        n = 0;
        while (src_rd[1] < 2 && n < 20) begin tick(); n++; end
        src_en[1] = 1'b0;
        drive();
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (s_ready !== 4'b0010) begin bad++; $display("FAIL lock_ready: got %b, required 0010", s_ready); end
            if (i >= 1) begin
                total++;
                if (s_valid !== 1'b0) begin bad++; $display("FAIL lock_bubble: got valid %b, required 0", s_valid); end
            end
        end
        src_en[1] = 1'b1;
        drive();
        drain();
    endtask

    task automatic test_backpressure();
        apply_reset();
        push_src(0, 3, 2);
        push_src(2, 3, 2);
        for (int i = 0; i < 3; i++) push_exp(bv(0, i), (i == 2), 0);
        for (int i = 0; i < 3; i++) push_exp(bv(2, i), (i == 2), 2);
        drive();
        tick();
        tick();
        i_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            total += 2;
            if (s_valid !== 1'b1 || s_value !== bv(0, 1)) begin
                bad++;
                $display("FAIL bp_hold: got valid=%b value=%h, required valid=1 value=%h", s_valid, s_value, bv(0, 1));
            end
            if (s_ready !== 4'b0000) begin bad++; $display("FAIL bp_ready: got %b, required 0000", s_ready); end
        end
        i_ready = 1'b1;
        drain();
    endtask

    task automatic test_reset_mid();
        int n;
        apply_reset();
        push_src(0, 4, 0);
        push_exp(bv(0, 0), 1'b0, 0);
        drive();
        n = 0;
        while (src_rd[0] < 2 && n < 20) begin tick(); n++; end
        reset_n = 1'b0;
        #1;
        total += 2;
        if (o_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b, required 0", o_valid); end
        if (exp_q.size() != 0) begin bad++; $display("FAIL midrst_pending: got %0d beats outstanding, required 0", exp_q.size()); end
        for (int k = 0; k < N; k++) begin
            src_rd[k] = 0;
            src_wr[k] = 0;
        end
        drive();
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        push_src(1, 1, 2);
        push_src(0, 1, 2);
        push_exp(bv(0, 0), 1'b1, 0);
        push_exp(bv(1, 0), 1'b1, 1);
        drive();
        tick();
        total++;
        if (s_ready !== 4'b0001) begin bad++; $display("FAIL midrst_winner: got %b, required 0001", s_ready); end
        drain();
    endtask

    initial begin
        i_value = '0;
        i_valid = '0;
        i_last  = '0;
        test_reset();
        test_single();
        test_rr_last();
        test_rr_burst();
        test_lock_hold();
        test_backpressure();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000");
        $fatal(1);
    end

endmodule
